// File: rtl/bus_seq_pkg.sv
// ---------------------------------------------------------------------------
// bus_seq_pkg
// Shared definitions for the bus cycle sequencer:
//   - default data/address widths
//   - strobe levels (the bus strobes are active-low)
//   - sequencer state encoding
//   - strobe_level(): maps a state and an "operation selected" flag to a
//     strobe level, so the Rd and Wr strobes come from one piece of logic
//     and cannot drift apart.
// Optional feature macro used by the files that import this package:
//   BUS_SEQ_TIMEOUT_EN (T2 wait-state timeout).
// ---------------------------------------------------------------------------
package bus_seq_pkg;

  localparam int DEF_DW = 4;
  localparam int DEF_AW = 4;

  // Bus strobes are active-low.
  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_DONE = 3'd4
  } seq_state_t;

  // A strobe is driven only in T2/T3, and only when its operation is the one
  // in flight. Because callers pass complementary flags for Rd and Wr, the
  // two strobes can never be low together.
  function automatic logic strobe_level(input seq_state_t st, input logic op_sel);
    if (op_sel && ((st == S_T2) || (st == S_T3))) begin
      return STB_ON;
    end
    return STB_OFF;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// ---------------------------------------------------------------------------
// bus_wait_timer
// Counts wait-state cycles for the sequencer's T2 phase and flags when the
// allowed number of waits has been used up. Present only when the
// BUS_SEQ_TIMEOUT_EN macro is defined; without the macro this file declares
// no module.
// Parameters:
//   WAIT_MAX  number of Ready=1 cycles tolerated before expired (>= 1)
// Ports:
//   Clk       in  clock, rising edge
//   Rst       in  asynchronous reset, active-low
//   clear     in  synchronous clear of the wait count
//   count_en  in  count one wait cycle
//   expired   out count has reached WAIT_MAX
// ---------------------------------------------------------------------------
`ifdef BUS_SEQ_TIMEOUT_EN
module bus_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] count_q;

  assign expired = (count_q == LIMIT);

  // Saturates at WAIT_MAX so a stalled caller cannot wrap the count.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/bus_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// bus_cycle_sequencer
// Turns single CPU requests (read/write, address, data) into phased bus
// cycles IDLE -> T1 -> T2 (wait)* -> T3 -> DONE -> IDLE, driving the address,
// the write data and the active-low Rd/Wr strobes, waiting for the active-low
// Ready, and returning read data or completion as a one-cycle response pulse.
// One transaction in flight; requests arriving while busy are ignored.
// All outputs are registered.
//
// Optional feature: define BUS_SEQ_TIMEOUT_EN to abort a T2 phase that sees
// more than WAIT_MAX Ready=1 cycles (response with Rsp_Err=1, Rsp_Data=0).
// Without the macro T2 waits for Ready indefinitely and Rsp_Err stays 0.
//
// Parameters: DW data width, AW address width,
//             WAIT_MAX wait limit (only with BUS_SEQ_TIMEOUT_EN)
// Ports:
//   Clk, Rst                 clock / async active-low reset
//   Req_Valid, Req_Ready     request handshake
//   Req_Wr, Req_Addr,
//   Req_Data                 request contents, sampled on accept
//   Rsp_Valid, Rsp_Data,
//   Rsp_Err                  one-cycle response
//   Addr_Out, D_Out          bus address / write data
//   Rd, Wr                   bus strobes, active-low
//   Bus_D_In                 bus read data
//   Ready                    bus ready, active-low
// ---------------------------------------------------------------------------
module bus_cycle_sequencer
  import bus_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
`ifdef BUS_SEQ_TIMEOUT_EN
  ,
  parameter int WAIT_MAX = 15
`endif
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req_Valid,
  output logic          Req_Ready,
  input  logic          Req_Wr,
  input  logic [AW-1:0] Req_Addr,
  input  logic [DW-1:0] Req_Data,
  output logic          Rsp_Valid,
  output logic [DW-1:0] Rsp_Data,
  output logic          Rsp_Err,
  output logic [AW-1:0] Addr_Out,
  output logic [DW-1:0] D_Out,
  output logic          Rd,
  output logic          Wr,
  input  logic [DW-1:0] Bus_D_In,
  input  logic          Ready
);

  seq_state_t    state_q, state_d;
  logic          is_write_q, is_write_d;
  logic          accept;
  logic          timeout_hit;
  logic          abort;

  logic          req_ready_d;
  logic          rsp_valid_d;
  logic [DW-1:0] rsp_data_d;
  logic          rsp_err_d;
  logic [AW-1:0] addr_out_d;
  logic [DW-1:0] d_out_d;
  logic          rd_d;
  logic          wr_d;

  // Req_Ready is registered and is 0 for the first cycle after reset, so the
  // first accept can only happen once it has risen.
  assign accept = (state_q == S_IDLE) && Req_Ready && Req_Valid;

`ifdef BUS_SEQ_TIMEOUT_EN
  // The timer is held clear outside T2, which clears it on every T2 entry,
  // and counts each T2 cycle that still sees Ready high.
  bus_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .clear    (state_q != S_T2),
    .count_en ((state_q == S_T2) && Ready),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Ready low wins over an expired timer: a cycle that completes on the last
  // permitted wait is a normal completion, not an abort.
  assign abort = (state_q == S_T2) && Ready && timeout_hit;

  // Next-state logic. Ready is looked at only in T2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (!Ready) begin
          state_d = S_T3;
        end else if (abort) begin
          state_d = S_DONE;
        end
      end
      S_T3:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register inputs are derived from the state being entered, so each
  // registered output is correct for the whole of that state. Addr_Out and
  // D_Out double as the latched request: loaded on accept, held until IDLE.
  always_comb begin
    is_write_d  = accept ? Req_Wr : is_write_q;
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    rsp_err_d   = abort;
    rsp_data_d  = '0;
    addr_out_d  = Addr_Out;
    d_out_d     = D_Out;

    // Read data is taken on the edge that ends T3; writes and aborts return 0.
    if ((state_q == S_T3) && !is_write_q) begin
      rsp_data_d = Bus_D_In;
    end

    if (accept) begin
      addr_out_d = Req_Addr;
      d_out_d    = Req_Wr ? Req_Data : '0;
    end else if (state_d == S_IDLE) begin
      addr_out_d = '0;
      d_out_d    = '0;
    end

    rd_d = strobe_level(state_d, !is_write_d);
    wr_d = strobe_level(state_d, is_write_d);
  end

  // State and output registers. Reset releases both strobes at once and
  // drops any transaction in flight without a response.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      Req_Ready  <= 1'b0;
      Rsp_Valid  <= 1'b0;
      Rsp_Data   <= '0;
      Rsp_Err    <= 1'b0;
      Addr_Out   <= '0;
      D_Out      <= '0;
      Rd         <= STB_OFF;
      Wr         <= STB_OFF;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      Req_Ready  <= req_ready_d;
      Rsp_Valid  <= rsp_valid_d;
      Rsp_Data   <= rsp_data_d;
      Rsp_Err    <= rsp_err_d;
      Addr_Out   <= addr_out_d;
      D_Out      <= d_out_d;
      Rd         <= rd_d;
      Wr         <= wr_d;
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_sequencer
// Directed bench for bus_cycle_sequencer: reset values, zero-wait read,
// write with three wait states, back-to-back requests, reset in mid-T2, and
// either the T2 timeout (BUS_SEQ_TIMEOUT_EN, WAIT_MAX=4) or an indefinite
// T2 stall followed by normal completion (macro undefined).
// ---------------------------------------------------------------------------
module tb_bus_cycle_sequencer;

  logic       Clk;
  logic       Rst;
  logic       Req_Valid;
  logic       Req_Ready;
  logic       Req_Wr;
  logic [3:0] Req_Addr;
  logic [3:0] Req_Data;
  logic       Rsp_Valid;
  logic [3:0] Rsp_Data;
  logic       Rsp_Err;
  logic [3:0] Addr_Out;
  logic [3:0] D_Out;
  logic       Rd;
  logic       Wr;
  logic [3:0] Bus_D_In;
  logic       Ready;

  int vecCount;
  int missCount;

  bus_cycle_sequencer #(
    .DW (4),
    .AW (4)
`ifdef BUS_SEQ_TIMEOUT_EN
    ,
    .WAIT_MAX (4)
`endif
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req_Valid (Req_Valid),
    .Req_Ready (Req_Ready),
    .Req_Wr    (Req_Wr),
    .Req_Addr  (Req_Addr),
    .Req_Data  (Req_Data),
    .Rsp_Valid (Rsp_Valid),
    .Rsp_Data  (Rsp_Data),
    .Rsp_Err   (Rsp_Err),
    .Addr_Out  (Addr_Out),
    .D_Out     (D_Out),
    .Rd        (Rd),
    .Wr        (Wr),
    .Bus_D_In  (Bus_D_In),
    .Ready     (Ready)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard stop in case a step sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives all request/bus inputs together.
  task automatic applyStimulus(input logic valid, input logic wr,
                               input logic [3:0] addr, input logic [3:0] data,
                               input logic ready, input logic [3:0] busD);
    Req_Valid = valid;
    Req_Wr    = wr;
    Req_Addr  = addr;
    Req_Data  = data;
    Ready     = ready;
    Bus_D_In  = busD;
  endtask

  // Advances to 1 time unit after the next rising edge, where registered
  // outputs are settled and inputs may be changed for the following edge.
  task automatic stepClock();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;

    // ---------------- reset values ----------------
    Rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    repeat (2) stepClock();
    checkOutput("rst_req_ready", Req_Ready, 4'h0);
    checkOutput("rst_rsp_valid", Rsp_Valid, 4'h0);
    checkOutput("rst_rsp_data",  Rsp_Data,  4'h0);
    checkOutput("rst_rsp_err",   Rsp_Err,   4'h0);
    checkOutput("rst_addr_out",  Addr_Out,  4'h0);
    checkOutput("rst_d_out",     D_Out,     4'h0);
    checkOutput("rst_rd",        Rd,        4'h1);
    checkOutput("rst_wr",        Wr,        4'h1);
    Rst = 1'b1;
    stepClock();
    checkOutput("rel_req_ready", Req_Ready, 4'h1);

    // ---------------- zero-wait read ----------------
    applyStimulus(1'b1, 1'b0, 4'hA, 4'h0, 1'b0, 4'h5);
    stepClock();                                   // accept edge N
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h5);
    checkOutput("rd0_t1_req_ready", Req_Ready, 4'h0);
    checkOutput("rd0_t1_addr",      Addr_Out,  4'hA);
    checkOutput("rd0_t1_rd",        Rd,        4'h1);
    checkOutput("rd0_t1_dout",      D_Out,     4'h0);
    stepClock();                                   // T2
    checkOutput("rd0_t2_rd",        Rd,        4'h0);
    checkOutput("rd0_t2_wr",        Wr,        4'h1);
    checkOutput("rd0_t2_rsp_valid", Rsp_Valid, 4'h0);
    stepClock();                                   // T3
    checkOutput("rd0_t3_rd",        Rd,        4'h0);
    checkOutput("rd0_t3_rsp_valid", Rsp_Valid, 4'h0);
    stepClock();                                   // DONE (cycle N+4)
    checkOutput("rd0_done_rd",        Rd,        4'h1);
    checkOutput("rd0_done_rsp_valid", Rsp_Valid, 4'h1);
    checkOutput("rd0_done_rsp_data",  Rsp_Data,  4'h5);
    checkOutput("rd0_done_rsp_err",   Rsp_Err,   4'h0);
    checkOutput("rd0_done_addr",      Addr_Out,  4'hA);
    stepClock();                                   // IDLE
    checkOutput("rd0_idle_rsp_valid", Rsp_Valid, 4'h0);
    checkOutput("rd0_idle_req_ready", Req_Ready, 4'h1);
    checkOutput("rd0_idle_addr",      Addr_Out,  4'h0);

    // ---------------- write with three wait states ----------------
    applyStimulus(1'b1, 1'b1, 4'h3, 4'hC, 1'b1, 4'h0);
    stepClock();                                   // accept edge N
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    checkOutput("wr3_t1_dout", D_Out,    4'hC);
    checkOutput("wr3_t1_addr", Addr_Out, 4'h3);
    checkOutput("wr3_t1_wr",   Wr,       4'h1);
    // Four T2 cycles: the edges after the first three see Ready=1.
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput("wr3_t2_wr",        Wr,        4'h0);
      checkOutput("wr3_t2_rd",        Rd,        4'h1);
      checkOutput("wr3_t2_rsp_valid", Rsp_Valid, 4'h0);
    end
    Ready = 1'b0;
    stepClock();                                   // T3
    checkOutput("wr3_t3_wr",   Wr,    4'h0);
    checkOutput("wr3_t3_dout", D_Out, 4'hC);
    stepClock();                                   // DONE (cycle N+7)
    checkOutput("wr3_done_wr",        Wr,        4'h1);
    checkOutput("wr3_done_rsp_valid", Rsp_Valid, 4'h1);
    checkOutput("wr3_done_rsp_data",  Rsp_Data,  4'h0);
    checkOutput("wr3_done_rsp_err",   Rsp_Err,   4'h0);
    checkOutput("wr3_done_dout",      D_Out,     4'hC);
    stepClock();                                   // IDLE
    checkOutput("wr3_idle_rsp_valid", Rsp_Valid, 4'h0);
    checkOutput("wr3_idle_dout",      D_Out,     4'h0);

    // ---------------- back-to-back with Req_Valid held ----------------
    applyStimulus(1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 4'h9);
    stepClock();                                   // accept first (read)
    applyStimulus(1'b1, 1'b1, 4'h2, 4'h6, 1'b0, 4'h9);
    for (int i = 0; i < 3; i++) begin              // T1, T2, T3
      checkOutput("b2b_busy_req_ready", Req_Ready, 4'h0);
      checkOutput("b2b_busy_addr",      Addr_Out,  4'h1);
      checkOutput("b2b_no_dual_strobe", {3'b000, Rd | Wr}, 4'h1);
      stepClock();
    end
    checkOutput("b2b_done1_rsp_valid", Rsp_Valid, 4'h1);
    checkOutput("b2b_done1_rsp_data",  Rsp_Data,  4'h9);
    checkOutput("b2b_done1_req_ready", Req_Ready, 4'h0);
    stepClock();                                   // IDLE, not yet accepted
    checkOutput("b2b_idle_req_ready", Req_Ready, 4'h1);
    checkOutput("b2b_idle_addr",      Addr_Out,  4'h0);
    checkOutput("b2b_idle_rsp_valid", Rsp_Valid, 4'h0);
    stepClock();                                   // accept second (write)
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h9);
    checkOutput("b2b_t1_addr",      Addr_Out,  4'h2);
    checkOutput("b2b_t1_dout",      D_Out,     4'h6);
    checkOutput("b2b_t1_req_ready", Req_Ready, 4'h0);
    stepClock();                                   // T2
    checkOutput("b2b_t2_wr", Wr, 4'h0);
    checkOutput("b2b_t2_rd", Rd, 4'h1);
    stepClock();                                   // T3
    checkOutput("b2b_t3_no_dual_strobe", {3'b000, Rd | Wr}, 4'h1);
    stepClock();                                   // DONE
    checkOutput("b2b_done2_rsp_valid", Rsp_Valid, 4'h1);
    checkOutput("b2b_done2_rsp_data",  Rsp_Data,  4'h0);
    stepClock();                                   // IDLE

    // ---------------- reset in the middle of a read's T2 ----------------
    applyStimulus(1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 4'h3);
    stepClock();                                   // accept
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h3);
    stepClock();                                   // T2
    checkOutput("mrst_t2_rd", Rd, 4'h0);
    #2;
    Rst = 1'b0;
    #1;
    checkOutput("mrst_rd",        Rd,        4'h1);
    checkOutput("mrst_req_ready", Req_Ready, 4'h0);
    checkOutput("mrst_rsp_valid", Rsp_Valid, 4'h0);
    checkOutput("mrst_addr",      Addr_Out,  4'h0);
    for (int i = 0; i < 2; i++) begin
      stepClock();
      checkOutput("mrst_hold_rsp_valid", Rsp_Valid, 4'h0);
      checkOutput("mrst_hold_req_ready", Req_Ready, 4'h0);
    end
    Rst = 1'b1;
    stepClock();
    checkOutput("mrst_rel_req_ready", Req_Ready, 4'h1);
    checkOutput("mrst_rel_rsp_valid", Rsp_Valid, 4'h0);

`ifdef BUS_SEQ_TIMEOUT_EN
    // ---------------- timeout, WAIT_MAX = 4 ----------------
    applyStimulus(1'b1, 1'b0, 4'h8, 4'h0, 1'b1, 4'hF);
    stepClock();                                   // accept
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'hF);
    checkOutput("tmo_t1_rd", Rd, 4'h1);
    // Five T2 cycles: count 0..4, the edge that sees count=4 aborts.
    for (int i = 0; i < 5; i++) begin
      stepClock();
      checkOutput("tmo_t2_rd",        Rd,        4'h0);
      checkOutput("tmo_t2_rsp_valid", Rsp_Valid, 4'h0);
    end
    stepClock();                                   // DONE by abort
    checkOutput("tmo_done_rsp_valid", Rsp_Valid, 4'h1);
    checkOutput("tmo_done_rsp_err",   Rsp_Err,   4'h1);
    checkOutput("tmo_done_rsp_data",  Rsp_Data,  4'h0);
    checkOutput("tmo_done_rd",        Rd,        4'h1);
    checkOutput("tmo_done_wr",        Wr,        4'h1);
    stepClock();
    checkOutput("tmo_idle_rsp_valid", Rsp_Valid, 4'h0);
    checkOutput("tmo_idle_rsp_err",   Rsp_Err,   4'h0);
    checkOutput("tmo_idle_req_ready", Req_Ready, 4'h1);
`else
    // ---------------- indefinite T2 stall, then completion ----------------
    applyStimulus(1'b1, 1'b0, 4'h8, 4'h0, 1'b1, 4'hF);
    stepClock();                                   // accept
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'hF);
    for (int i = 0; i < 100; i++) begin
      stepClock();
      checkOutput("stall_t2_rd",        Rd,        4'h0);
      checkOutput("stall_t2_rsp_valid", Rsp_Valid, 4'h0);
    end
    Ready = 1'b0;
    stepClock();                                   // T3
    checkOutput("stall_t3_rd", Rd, 4'h0);
    stepClock();                                   // DONE
    checkOutput("stall_done_rsp_valid", Rsp_Valid, 4'h1);
    checkOutput("stall_done_rsp_data",  Rsp_Data,  4'hF);
    checkOutput("stall_done_rsp_err",   Rsp_Err,   4'h0);
    checkOutput("stall_done_rd",        Rd,        4'h1);
    stepClock();
    checkOutput("stall_idle_rsp_valid", Rsp_Valid, 4'h0);
    checkOutput("stall_idle_req_ready", Req_Ready, 4'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
